// File: rtl/bayer_pkg.sv
// Shared types for the Bayer 2x2 window generator.
//   pixel_t     : one raw 8-bit Bayer sample
//   window_t    : 2x2 neighbourhood {tl, tr, bl, br}
//   win_state_t : frame-tracking FSM states
package bayer_pkg;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    pixel_t tl;
    pixel_t tr;
    pixel_t bl;
    pixel_t br;
  } window_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIRST_ROW = 2'd1,
    ROWS      = 2'd2,
    DONE      = 2'd3
  } win_state_t;

  // Width of a counter that must hold 0..n-1 (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bayer_window_line_buffer.sv
// One-line pixel store.
//   clk_i   : clock
//   we_i    : write strobe
//   addr_i  : shared read/write address
//   wdata_i : pixel to write
//   rdata_o : pixel currently stored at addr_i (combinational read)
// A read during a write at the same address returns the old contents,
// which is what lets the top read pixel (x,y-1) while storing (x,y).
module line_buffer
  import bayer_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bayer_window.sv
// Raster Bayer stream to overlapping 2x2 windows.
//   clk, n_rst           : clock, async active-low reset
//   sof, pixel_valid     : beat qualifiers (sof marks pixel (0,0))
//   pixel_in             : raw Bayer sample
//   win_valid, win_1..4  : registered window (TL, TR, BL, BR), 1-cycle latency
//   row, col             : parity of the window's top-left pixel
//   frame_done           : pulses with the last window of a frame
//   busy                 : high while a frame is being received
module bayer_window
  import bayer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sof,
  input  logic       pixel_valid,
  input  logic [7:0] pixel_in,
  output logic       win_valid,
  output logic [7:0] win_1,
  output logic [7:0] win_2,
  output logic [7:0] win_3,
  output logic [7:0] win_4,
  output logic       row,
  output logic       col,
  output logic       frame_done,
  output logic       busy
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  win_state_t    state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  pixel_t        top_prev_q;   // old lbuf[x-1], i.e. pixel (x-1,y-1)
  pixel_t        bot_prev_q;   // pixel (x-1,y)
  window_t       win_q;
  logic          win_valid_q, row_q, col_q, frame_done_q;

  // sof with a valid beat restarts from any state; plain beats only count
  // while a frame is in progress.
  logic start_d, run_d;
  assign start_d = pixel_valid & sof;
  assign run_d   = pixel_valid & ~sof & ((state_q == FIRST_ROW) | (state_q == ROWS));

  logic [XW-1:0] lb_addr_d;
  pixel_t        lb_rdata;
  assign lb_addr_d = start_d ? '0 : x_q;

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lbuf (
    .clk_i   (clk),
    .we_i    (start_d | run_d),
    .addr_i  (lb_addr_d),
    .wdata_i (pixel_in),
    .rdata_o (lb_rdata)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      top_prev_q   <= '0;
      bot_prev_q   <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      row_q        <= 1'b0;
      col_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q == DONE) state_q <= IDLE;

      if (start_d) begin
        // Beat is (0,0); next expected position is (1,0).
        state_q    <= FIRST_ROW;
        x_q        <= XW'(1);
        y_q        <= '0;
        bot_prev_q <= pixel_in;
      end else if (run_d) begin
        top_prev_q <= lb_rdata;
        bot_prev_q <= pixel_in;

        if (state_q == ROWS && x_q != '0) begin
          win_valid_q <= 1'b1;
          win_q       <= '{tl: top_prev_q, tr: lb_rdata, bl: bot_prev_q, br: pixel_in};
          row_q       <= ~y_q[0];   // (y-1) & 1
          col_q       <= ~x_q[0];   // (x-1) & 1
        end

        if (x_q == X_LAST) begin
          x_q <= '0;
          if (state_q == FIRST_ROW) begin
            y_q     <= YW'(1);
            state_q <= ROWS;
          end else if (y_q == Y_LAST) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end else begin
            y_q <= y_q + YW'(1);
          end
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_1      = win_q.tl;
  assign win_2      = win_q.tr;
  assign win_3      = win_q.bl;
  assign win_4      = win_q.br;
  assign row        = row_q;
  assign col        = col_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == FIRST_ROW) | (state_q == ROWS);

endmodule

// File: tb/tb_bayer_window.sv
// Bench for bayer_window (4x3 image): image-level reference model plus
// hand-computed literal windows from the 16*y+x test pattern.
module tb_bayer_window;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       n_rst, sof, pixel_valid;
  logic [7:0] pixel_in;
  logic       win_valid, row, col, frame_done, busy;
  logic [7:0] win_1, win_2, win_3, win_4;

  bayer_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .n_rst(n_rst), .sof(sof), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .win_valid(win_valid), .win_1(win_1), .win_2(win_2),
    .win_3(win_3), .win_4(win_4), .row(row), .col(col),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int nwin = 0, nfd = 0;

  // Reference model: the image received so far and the current position.
  logic [7:0] img [H][W];
  bit         m_active = 0;
  int         m_x = 0, m_y = 0;
  logic       e_valid = 0, e_row = 0, e_col = 0, e_fd = 0, e_busy = 0;
  logic [7:0] e_w1 = 0, e_w2 = 0, e_w3 = 0, e_w4 = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_x = 0; m_y = 0;
    e_valid = 0; e_row = 0; e_col = 0; e_fd = 0; e_busy = 0;
    e_w1 = 0; e_w2 = 0; e_w3 = 0; e_w4 = 0;
  endtask

  task automatic model_beat(input logic v, input logic s, input logic [7:0] p);
    e_valid = 0; e_fd = 0;
    if (v && s) begin
      img[0][0] = p; m_x = 1; m_y = 0; m_active = 1;
    end else if (v && m_active) begin
      img[m_y][m_x] = p;
      if (m_x >= 1 && m_y >= 1) begin
        e_valid = 1;
        e_w1 = img[m_y-1][m_x-1]; e_w2 = img[m_y-1][m_x];
        e_w3 = img[m_y][m_x-1];   e_w4 = p;
        e_row = 1'((m_y - 1) & 1); e_col = 1'((m_x - 1) & 1);
      end
      if (m_x == W - 1) begin
        m_x = 0;
        if (m_y == H - 1) begin m_active = 0; e_fd = 1; end
        else m_y++;
      end else m_x++;
    end
    e_busy = m_active;
  endtask

  task automatic compare_all();
    chk("win_valid", 8'(win_valid), 8'(e_valid));
    chk("frame_done", 8'(frame_done), 8'(e_fd));
    chk("busy", 8'(busy), 8'(e_busy));
    chk("win_1", win_1, e_w1);
    chk("win_2", win_2, e_w2);
    chk("win_3", win_3, e_w3);
    chk("win_4", win_4, e_w4);
    chk("row", 8'(row), 8'(e_row));
    chk("col", 8'(col), 8'(e_col));
  endtask

  // Drive one cycle at the negedge, check results at the following negedge.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    pixel_valid = v; sof = s; pixel_in = p;
    model_beat(v, s, p);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    if (win_valid) nwin++;
    if (frame_done) nfd++;
  endtask

  task automatic lit(input string nm, input logic [7:0] a, b, c, d, input logic r, cl);
    chk({nm, "_valid"}, 8'(win_valid), 8'd1);
    chk({nm, "_w1"}, win_1, a);
    chk({nm, "_w2"}, win_2, b);
    chk({nm, "_w3"}, win_3, c);
    chk({nm, "_w4"}, win_4, d);
    chk({nm, "_row"}, 8'(row), 8'(r));
    chk({nm, "_col"}, 8'(col), 8'(cl));
  endtask

  function automatic logic [7:0] pat(input int x, input int y);
    return 8'(16 * y + x);
  endfunction

  // Full pattern frame; gap cycles inserted after every other beat.
  task automatic pattern_frame(input int gap);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        step(1'b1, (x == 0 && y == 0), pat(x, y));
        if (x == 1 && y == 1) lit("first_win", 8'h00, 8'h01, 8'h10, 8'h11, 1'b0, 1'b0);
        if (x == 2 && y == 1) lit("second_win", 8'h01, 8'h02, 8'h11, 8'h12, 1'b0, 1'b1);
        if (x == 3 && y == 2) begin
          lit("last_win", 8'h12, 8'h13, 8'h22, 8'h23, 1'b1, 1'b0);
          chk("last_fd", 8'(frame_done), 8'd1);
        end
        if (((y * W + x) % 2) == 1)
          for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 8'($urandom));
            chk("gap_no_win", 8'(win_valid), 8'd0);
          end
      end
  endtask

  initial begin
    n_rst = 1'b0; sof = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    n_rst = 1'b1;

    // Continuous frame.
    nwin = 0; nfd = 0;
    pattern_frame(0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("busy_after_done", 8'(busy), 8'd0);
    chk("cont_windows", 8'(nwin), 8'd6);
    chk("cont_fd", 8'(nfd), 8'd1);

    // Same frame with idle gaps.
    nwin = 0; nfd = 0;
    pattern_frame(3);
    step(1'b0, 1'b0, 8'h00);
    chk("gap_windows", 8'(nwin), 8'd6);
    chk("gap_fd", 8'(nfd), 8'd1);

    // Beats without sof while idle, then a real frame.
    nwin = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("idle_no_win", 8'(nwin), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);
    pattern_frame(0);

    // sof reasserted at (2,1).
    nwin = 0; nfd = 0;
    for (int i = 0; i < W + 2; i++) step(1'b1, i == 0, pat(i % W, i / W));
    step(1'b1, 1'b1, 8'h00);            // restart, no window for this beat
    chk("restart_no_win", 8'(win_valid), 8'd0);
    chk("restart_no_fd", 8'(nfd), 8'd0);
    for (int i = 1; i < W * H; i++) begin
      step(1'b1, 1'b0, pat(i % W, i / W));
      if (i == W + 1) lit("restart_win", 8'h00, 8'h01, 8'h10, 8'h11, 1'b0, 1'b0);
    end
    chk("restart_windows", 8'(nwin), 8'd7);
    chk("restart_fd", 8'(nfd), 8'd1);

    // Reset pulsed while the (3,1) beat is on the inputs.
    for (int i = 0; i < W + 3; i++) step(1'b1, i == 0, pat(i % W, i / W));
    pixel_valid = 1'b1; sof = 1'b0; pixel_in = pat(3, 1);
    #1 n_rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    n_rst = 1'b1;
    nwin = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("post_reset_no_win", 8'(nwin), 8'd0);
    pattern_frame(1);

    // Randomized traffic: gaps, random sof restarts, stray beats.
    for (int i = 0; i < 1500; i++) begin
      logic v, s;
      v = ($urandom_range(3, 0) != 0);
      s = v && ($urandom_range(19, 0) == 0);
      step(v, s, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bayer_window.md
Name: bayer_window

Overview:
- Converts a raster stream of raw 8-bit Bayer pixels into overlapping 2x2 windows.
- Each window carries the row and column parity of its top-left pixel.
- Sits upstream of the white-balance stage, which feeds the Bayer channel mux.
- Holds one image line in a line buffer and tracks frame position with counters and a small FSM.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=2).
- IMG_HEIGHT, 480, lines per frame (>=2).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- sof  in  1  start-of-frame; qualifies a pixel_valid beat as pixel (0,0).
- pixel_valid  in  1  pixel_in is valid this cycle (no backpressure).
- pixel_in  in  8  raw Bayer pixel.
- win_valid  out  1  window outputs valid this cycle.
- win_1  out  8  top-left pixel (x-1,y-1).
- win_2  out  8  top-right pixel (x,y-1).
- win_3  out  8  bottom-left pixel (x-1,y).
- win_4  out  8  bottom-right pixel (x,y).
- row  out  1  (y-1) & 1, parity of the top-left pixel row.
- col  out  1  (x-1) & 1, parity of the top-left pixel column.
- frame_done  out  1  one-cycle pulse with the last window of a frame.
- busy  out  1  high while in FIRST_ROW or ROWS.

Behaviour:
- Reset: all outputs 0, state IDLE, x=y=0, line buffer contents don't-care.
- FSM states:
  - IDLE: beats without sof are ignored. A beat with pixel_valid&sof is accepted as (0,0) and moves to FIRST_ROW.
  - FIRST_ROW (y=0): write each pixel to lbuf[x]. When the beat at x=IMG_WIDTH-1 is accepted, go to ROWS with y=1, x=0.
  - ROWS: each accepted beat reads old lbuf[x] = pixel(x,y-1), then writes pixel_in to lbuf[x].
  - DONE: entered after (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted. Returns to IDLE next cycle.
- Internal registers:
  - top_prev holds lbuf[x-1] (old value).
  - bot_prev holds the pixel at (x-1,y).
- Window emission:
  - For an accepted beat at x>=1, y>=1, the registered outputs the next cycle are win_1=top_prev, win_2=old lbuf[x], win_3=bot_prev, win_4=pixel_in, row=(y-1)&1, col=(x-1)&1, win_valid=1.
  - Latency is 1 cycle.
  - No window is emitted for x=0 or y=0.
  - Exactly (IMG_WIDTH-1)*(IMG_HEIGHT-1) windows are emitted per frame.
- Counters: x wraps from IMG_WIDTH-1 to 0 and increments y. Counter widths are $clog2 of the parameter.
- Idle cycles (pixel_valid=0): counters and registers hold; win_valid=0 the next cycle.
- frame_done: asserted in the same cycle as the window for (IMG_WIDTH-1, IMG_HEIGHT-1).
- sof at any other time (FIRST_ROW or ROWS, with pixel_valid): the current frame is abandoned without frame_done. The beat is taken as (0,0) of a new frame, the FSM goes to FIRST_ROW, and no window is emitted for that beat.
- Beats after the final pixel without sof: ignored.
- Reset asserted mid-frame: immediately returns to the reset values. The next frame requires sof.
- Outputs hold their last values when win_valid=0, except frame_done, which is 0.

Decomposition:
- Shared package `bayer_pkg`:
  - pixel_t (logic [7:0]).
  - window_t struct {tl,tr,bl,br}.
  - Enum win_state_t {IDLE, FIRST_ROW, ROWS, DONE}.
- Sub-module `line_buffer`:
  - Parameterised depth IMG_WIDTH, 8-bit.
  - Synchronous write, combinational read at the same address.
  - Read returns the old data on a simultaneous write.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, pixel (x,y) = 16*y + x):
- Full frame, continuous valid, sof on first beat:
  - The cycle after (1,1), expect win_1..4 = 0x00, 0x01, 0x10, 0x11, row=0, col=0.
  - Next window: 0x01, 0x02, 0x11, 0x12 with col=1.
  - Exactly 6 windows in total.
- Last window: expect 0x12, 0x13, 0x22, 0x23 with row=1, col=0, together with a single frame_done pulse. busy=0 two cycles later.
- Same frame with pixel_valid=0 for 3 cycles every other beat: identical window sequence and values. win_valid stays low during gaps.
- Beats without sof while IDLE: no windows. A later sof frame still produces the first window 0x00, 0x01, 0x10, 0x11.
- sof reasserted at (2,1) mid-frame: no frame_done. Windows restart, and the first new window follows (1,1) of the new frame.
- n_rst pulsed low at (3,1): all outputs 0 immediately. No windows until the next sof.
